// File: rtl/des_decryption_unroll4_pkg.sv
// Shared DES constants and helpers: permutation tables, S-boxes, Feistel f and
// the FSM encoding, used by the decryption, encryption and key-schedule blocks.
package des_decryption_unroll4_pkg;

  localparam int NUM_ROUNDS = 16;
  localparam int UNROLL     = 4;
  localparam int KEY_W      = 48;
  localparam logic [1:0] LAST_CYCLE = 2'(NUM_ROUNDS / UNROLL - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Tables use DES numbering: entry n names the source bit (1 = MSB).
  localparam logic [6:0] IP_TBL [0:63] = '{
    7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
    7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
    7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
    7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
    7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
    7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
  };

  localparam logic [6:0] FP_TBL [0:63] = '{
    7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
    7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
    7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
    7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
    7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
    7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
    7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
    7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
  };

  localparam logic [5:0] E_TBL [0:47] = '{
    6'd32, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,
    6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd9,
    6'd8,  6'd9,  6'd10, 6'd11, 6'd12, 6'd13,
    6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
    6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
    6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25,
    6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
    6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd1
  };

  localparam logic [5:0] P_TBL [0:31] = '{
    6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
    6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
    6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
    6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
  };

  // One S-box per entry; nibble k (from the MSB end) holds row*16+col = k.
  localparam logic [255:0] SBOX [0:7] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [1:64] ip_perm(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 1; i <= 64; i++) y[i] = x[IP_TBL[i-1]];
    return y;
  endfunction

  function automatic logic [1:64] fp_perm(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 1; i <= 64; i++) y[i] = x[FP_TBL[i-1]];
    return y;
  endfunction

  function automatic logic [1:48] e_expand(input logic [1:32] x);
    logic [1:48] y;
    for (int i = 1; i <= 48; i++) y[i] = x[E_TBL[i-1]];
    return y;
  endfunction

  function automatic logic [1:32] p_perm(input logic [1:32] x);
    logic [1:32] y;
    for (int i = 1; i <= 32; i++) y[i] = x[P_TBL[i-1]];
    return y;
  endfunction

  // Outer bits select the row, inner four bits the column.
  function automatic logic [3:0] sbox_lookup(input int n, input logic [5:0] b);
    logic [5:0]   idx;
    logic [255:0] tbl;
    idx = {b[5], b[0], b[4:1]};
    tbl = SBOX[n];
    return tbl[255 - 4 * int'(idx) -: 4];
  endfunction

  function automatic logic [1:32] feistel_f(input logic [1:32] r, input logic [1:48] k);
    logic [1:48] x;
    logic [1:32] s;
    x = e_expand(r) ^ k;
    for (int n = 0; n < 8; n++) s[4*n+1 +: 4] = sbox_lookup(n, x[6*n+1 +: 6]);
    return p_perm(s);
  endfunction

endpackage

// File: rtl/des_round_core.sv
// One combinational DES Feistel round: L' = R, R' = L xor f(R, K).
module des_round_core
  import des_decryption_unroll4_pkg::*;
(
  input  logic [1:32] l_in,
  input  logic [1:32] r_in,
  input  logic [1:48] k,
  output logic [1:32] l_out,
  output logic [1:32] r_out
);

  assign l_out = r_in;
  assign r_out = l_in ^ feistel_f(r_in, k);

endmodule

// File: rtl/des_decryption_unroll4.sv
// Iterative DES decryption, four Feistel rounds per clock (16 rounds in 4 cycles).
// Takes round keys in encryption order and walks them backwards internally.
module des_decryption_unroll4
  import des_decryption_unroll4_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:64]  ciphertext,
  input  logic [1:768] round_keys,
  output logic         busy,
  output logic         done,
  output logic [1:64]  plaintext
);

  localparam int SHIFT_W = UNROLL * KEY_W;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [1:32]  l_q, l_d, r_q, r_d;
  logic [1:768] key_q, key_d;
  logic [1:64]  pt_q, pt_d;
  logic         busy_q, busy_d, done_q, done_d;

  logic [1:32]  l_s [0:UNROLL];
  logic [1:32]  r_s [0:UNROLL];
  logic [1:64]  ip_s;

  assign l_s[0] = l_q;
  assign r_s[0] = r_q;
  assign ip_s   = ip_perm(ciphertext);

  // The highest 4 key slots always hold the next keys, newest-first (K16 first).
  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    des_round_core u_round (
      .l_in  (l_s[g]),
      .r_in  (r_s[g]),
      .k     (key_q[(768 - KEY_W + 1) - KEY_W * g +: KEY_W]),
      .l_out (l_s[g+1]),
      .r_out (r_s[g+1])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    r_d     = r_q;
    key_d   = key_q;
    pt_d    = pt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          l_d     = ip_s[1:32];
          r_d     = ip_s[33:64];
          key_d   = round_keys;
          cnt_d   = 2'd0;
          state_d = ST_ROUND;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ROUND: begin
        l_d   = l_s[UNROLL];
        r_d   = r_s[UNROLL];
        key_d = {{SHIFT_W{1'b0}}, key_q[1:768-SHIFT_W]};
        if (cnt_q == LAST_CYCLE) begin
          // Final swap folded into the output permutation.
          pt_d    = fp_perm({r_s[UNROLL], l_s[UNROLL]});
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + 2'd1;
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      l_q     <= 32'd0;
      r_q     <= 32'd0;
      key_q   <= 768'd0;
      pt_q    <= 64'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign plaintext = pt_q;

endmodule

// File: tb/tb_des_decryption_unroll4.sv
// Directed bench for des_decryption_unroll4: published DES vectors, protocol
// corner cases (start while busy, back-to-back, mid-operation reset).
module tb_des_decryption_unroll4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:64]  ciphertext;
  logic [1:768] round_keys;
  logic         busy;
  logic         done;
  logic [1:64]  plaintext;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  localparam int PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17, 9,  1, 58, 50, 42, 34, 26, 18,
    10, 2,  59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6,  61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4
  };
  localparam int PC2 [0:47] = '{
    14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
    23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_decryption_unroll4 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ciphertext (ciphertext),
    .round_keys (round_keys),
    .busy       (busy),
    .done       (done),
    .plaintext  (plaintext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic [1:768] key_sched(input logic [1:64] key);
    logic [1:56]  cd;
    logic [1:28]  c, d;
    logic [1:768] rk;
    for (int i = 0; i < 56; i++) cd[i+1] = key[PC1[i]];
    c = cd[1:28];
    d = cd[29:56];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS[r]; s++) begin
        c = {c[2:28], c[1]};
        d = {d[2:28], d[1]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) rk[48*r + 1 + i] = cd[PC2[i]];
    end
    return rk;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge, then scramble the inputs.
  task automatic do_start(input logic [63:0] key, input logic [63:0] ct);
    logic [1:768] rk;
    rk = key_sched(key);
    start = 1'b1;
    ciphertext = ct;
    round_keys = rk;
    tick;
    start = 1'b0;
    ciphertext = ~ct;
    round_keys = ~rk;
  endtask

  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    while (done !== 1'b1 && n < 12) begin
      if (busy === 1'b1) nb++;
      tick;
      n++;
    end
  endtask

  task automatic run_kat(input string tag, input logic [63:0] key,
                         input logic [63:0] ct, input logic [63:0] pt);
    int n, nb, d0;
    d0 = done_cnt;
    do_start(key, ct);
    wait_done(n, nb);
    chk({tag, "_edges_to_done"}, 64'(n), 64'd4);
    chk({tag, "_busy_cycles"}, 64'(nb), 64'd4);
    chk({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    chk({tag, "_pt"}, plaintext, pt);
    tick;
    chk({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
    chk({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_pt_held"}, plaintext, pt);
  endtask

  initial begin
    int n, nb, d0;
    rst_n = 1'b0;
    start = 1'b0;
    ciphertext = '0;
    round_keys = '0;
    tick;
    tick;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_pt", plaintext, 64'd0);
    rst_n = 1'b1;
    tick;
    tick;
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_no_done", 64'(done_cnt), 64'd0);

    run_kat("fips", 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF);
    run_kat("zero_key", 64'h0101010101010101, 64'h8CA64DE9C1B123A7, 64'h0000000000000000);
    run_kat("ones_key", 64'hFEFEFEFEFEFEFEFE, 64'h7359B2163E4EDC58, 64'hFFFFFFFFFFFFFFFF);
    run_kat("fips_compl", 64'hECCBA8866443200E, 64'h7A17ECABF0F54BFA, 64'hFEDCBA9876543210);
    run_kat("k0e32", 64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787);
    run_kat("now_is", 64'h0123456789ABCDEF, 64'h3FA40E8A984D4815, 64'h4E6F772069732074);

    d0 = done_cnt;
    repeat (6) tick;
    chk("idle_hold_pt", plaintext, 64'h4E6F772069732074);
    chk("idle_hold_no_done", 64'(done_cnt - d0), 64'd0);

    // start pulses in busy cycles 2 and 3 carry other blocks and must be ignored
    d0 = done_cnt;
    do_start(64'h133457799BBCDFF1, 64'h85E813540F0AB405);
    tick;
    start = 1'b1;
    ciphertext = 64'h8CA64DE9C1B123A7;
    round_keys = key_sched(64'h0101010101010101);
    tick;
    ciphertext = 64'h7359B2163E4EDC58;
    round_keys = key_sched(64'hFEFEFEFEFEFEFEFE);
    tick;
    start = 1'b0;
    wait_done(n, nb);
    chk("busy_start_edges", 64'(n), 64'd1);
    chk("busy_start_pt", plaintext, 64'h0123456789ABCDEF);
    repeat (8) tick;
    chk("busy_start_one_done", 64'(done_cnt - d0), 64'd1);

    // second request arrives in the DONE cycle of the first
    d0 = done_cnt;
    do_start(64'h0101010101010101, 64'h8CA64DE9C1B123A7);
    wait_done(n, nb);
    chk("b2b_first_pt", plaintext, 64'h0000000000000000);
    do_start(64'h133457799BBCDFF1, 64'h85E813540F0AB405);
    n = 0;
    while (done !== 1'b1 && n < 12) begin
      chk("b2b_first_pt_held", plaintext, 64'h0000000000000000);
      tick;
      n++;
    end
    chk("b2b_done_gap", 64'(n + 1), 64'd5);
    chk("b2b_second_pt", plaintext, 64'h0123456789ABCDEF);
    tick;
    chk("b2b_done_count", 64'(done_cnt - d0), 64'd2);

    // reset during ROUND cycle 2 discards the block
    do_start(64'hECCBA8866443200E, 64'h7A17ECABF0F54BFA);
    tick;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_pt", plaintext, 64'd0);
    tick;
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (8) tick;
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("midrst_idle_busy", {63'd0, busy}, 64'd0);
    chk("midrst_pt_kept_zero", plaintext, 64'd0);
    run_kat("after_rst", 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
